// File: rtl/imem_boot_loader.sv
// Boot-time loader: assembles a little-endian byte stream into 32-bit words,
// writes them from address 0 into instruction memory, then releases the core.
module imem_boot_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          in_ready,
    input  logic          reload,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          core_rst,
    output logic          done,
    output logic          err,
    output logic [AW:0]   word_count,
    output logic [1:0]    dbg_state,
    output logic [1:0]    dbg_byte_idx
);

    // Handshake: a byte transfers on a rising edge when in_valid && in_ready;
    // in_ready comes from a flop and never depends on in_valid.

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

    localparam logic [AW:0] FULL = DEPTH[AW:0];

    state_t        state_q, state_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [23:0]   asm_q, asm_d;
    logic [AW:0]   word_count_q, word_count_d;
    logic          imem_we_q, imem_we_d;
    logic [AW-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]   imem_wdata_q, imem_wdata_d;
    logic          in_ready_q, in_ready_d;
    logic          core_rst_q, core_rst_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          accept;
    logic [AW:0]   wc_eff;

    assign accept = in_valid && in_ready_q;
    // Count including a write still on the port, so a byte right after a commit sees it.
    assign wc_eff = word_count_q + {{AW{1'b0}}, imem_we_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            byte_idx_q   <= 2'd0;
            asm_q        <= 24'd0;
            word_count_q <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            in_ready_q   <= 1'b1;
            core_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            word_count_q <= word_count_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            in_ready_q   <= in_ready_d;
            core_rst_q   <= core_rst_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        word_count_d = wc_eff;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        if (reload) begin
            state_d      = S_IDLE;
            byte_idx_d   = 2'd0;
            asm_d        = 24'd0;
            word_count_d = '0;
        end else if (accept) begin
            if (wc_eff == FULL) begin
                state_d = S_ERR;
            end else if (byte_idx_q == 2'd3) begin
                imem_we_d    = 1'b1;
                imem_addr_d  = wc_eff[AW-1:0];
                imem_wdata_d = {in_data, asm_q};
                byte_idx_d   = 2'd0;
                state_d      = in_last ? S_DONE : S_LOAD;
            end else if (in_last) begin
                state_d = S_ERR;
            end else begin
                case (byte_idx_q)
                    2'd0:    asm_d[7:0]   = in_data;
                    2'd1:    asm_d[15:8]  = in_data;
                    default: asm_d[23:16] = in_data;
                endcase
                byte_idx_d = byte_idx_q + 2'd1;
                state_d    = S_LOAD;
            end
        end
    end

    // Release waits one cycle in DONE so the final write lands before the core runs.
    always_comb begin
        in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
        done_d     = (state_q == S_DONE) && (state_d == S_DONE);
        core_rst_d = !done_d;
        err_d      = (state_d == S_ERR);
    end

    assign in_ready     = in_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign core_rst     = core_rst_q;
    assign done         = done_q;
    assign err          = err_q;
    assign word_count   = word_count_q;
    assign dbg_state    = state_q;
    assign dbg_byte_idx = byte_idx_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a per-cycle vector table for the basic
// image, hand-written sequences for gaps, errors, reload and async reset.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;
    logic        reload = 1'b0;
    logic        ovf_sel = 1'b0;

    logic        m_valid, s_valid;
    assign m_valid = in_valid & ~ovf_sel;
    assign s_valid = in_valid & ovf_sel;

    logic        in_ready, imem_we, core_rst, done, err;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [6:0]  word_count;
    logic [1:0]  dbg_state, dbg_byte_idx;

    logic        s_in_ready, s_imem_we, s_core_rst, s_done, s_err;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_wdata;
    logic [2:0]  s_wc;
    logic [1:0]  s_dbg_state, s_dbg_byte_idx;

    imem_boot_loader #(.DEPTH(64), .AW(6)) dut (
        .clk(clk), .rst(rst), .in_valid(m_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_rst(core_rst), .done(done), .err(err),
        .word_count(word_count), .dbg_state(dbg_state), .dbg_byte_idx(dbg_byte_idx)
    );

    imem_boot_loader #(.DEPTH(4), .AW(2)) dut_small (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(s_in_ready), .reload(reload), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
        .imem_wdata(s_imem_wdata), .core_rst(s_core_rst), .done(s_done), .err(s_err),
        .word_count(s_wc), .dbg_state(s_dbg_state), .dbg_byte_idx(s_dbg_byte_idx)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_fail = 0;
    int          s_wr_cnt = 0;
    logic [37:0] exp_q[$];
    logic [31:0] mem[64];

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            logic [37:0] e;
            mem[imem_addr] = imem_wdata;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: got addr=%0d data=%h, wanted no write", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0d data=%h, wanted addr=%0d data=%h",
                             imem_addr, imem_wdata, e[37:32], e[31:0]);
                end
            end
        end
        if (s_imem_we === 1'b1) s_wr_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic r);
        in_valid = v; in_data = d; in_last = l; reload = r;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; reload = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    logic [7:0] image [12] = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00,
                               8'h93, 8'h83, 8'h71, 8'hFF};

    task automatic push_image;
        exp_q.push_back({6'd0, 32'h00500113});
        exp_q.push_back({6'd1, 32'h00C00193});
        exp_q.push_back({6'd2, 32'hFF718393});
    endtask

    task automatic send_image(input int gap);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, image[i], i == 11, 1'b0);
            if (i != 11) idle(gap);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        valid;
        logic [7:0]  data;
        logic        last;
        logic        rld;
        logic        e_we;
        logic [5:0]  e_addr;
        logic [31:0] e_wdata;
        logic        e_ready;
        logic        e_core_rst;
        logic        e_done;
        logic        e_err;
        logic [6:0]  e_wc;
    } vec_t;

    vec_t tbl[14];

    task automatic setv(input int i, input logic v, input logic [7:0] d, input logic l,
                        input logic we, input logic [5:0] a, input logic [31:0] wd,
                        input logic rdy, input logic crst, input logic dn, input logic [6:0] wc);
        tbl[i] = '{v, d, l, 1'b0, we, a, wd, rdy, crst, dn, 1'b0, wc};
    endtask

    int x2;

    initial begin
        for (int i = 0; i < 12; i++) begin
            logic we;
            logic [5:0] a;
            logic [31:0] wd;
            we = (i % 4) == 3;
            a  = 6'(i / 4);
            wd = (i == 3) ? 32'h00500113 : (i == 7) ? 32'h00C00193 : 32'hFF718393;
            setv(i, 1'b1, image[i], i == 11, we, a, wd, i != 11, 1'b1, 1'b0, 7'(i / 4));
        end
        setv(12, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b1, 7'd3);
        setv(13, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b1, 7'd3);

        // reset
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("reset_outputs", {in_ready, imem_we, core_rst, done, err, dbg_state, dbg_byte_idx},
              {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0});
        check("reset_wc", 32'(word_count), 32'd0);

        // three-word image, table driven
        push_image();
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].valid, tbl[i].data, tbl[i].last, tbl[i].rld);
            n_vec++;
            if (in_ready !== tbl[i].e_ready || imem_we !== tbl[i].e_we || core_rst !== tbl[i].e_core_rst ||
                done !== tbl[i].e_done || err !== tbl[i].e_err || word_count !== tbl[i].e_wc ||
                (tbl[i].e_we && (imem_addr !== tbl[i].e_addr || imem_wdata !== tbl[i].e_wdata))) begin
                n_fail++;
                $display("FAIL vec%0d: got rdy=%0b we=%0b addr=%0d wd=%h crst=%0b done=%0b err=%0b wc=%0d, wanted rdy=%0b we=%0b addr=%0d wd=%h crst=%0b done=%0b err=%0b wc=%0d",
                         i, in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err, word_count,
                         tbl[i].e_ready, tbl[i].e_we, tbl[i].e_addr, tbl[i].e_wdata, tbl[i].e_core_rst,
                         tbl[i].e_done, tbl[i].e_err, tbl[i].e_wc);
            end
        end
        // the core's first instruction: addi x2, x0, imm
        if (mem[0][6:0] == 7'h13 && mem[0][11:7] == 5'd2 && mem[0][14:12] == 3'd0 && mem[0][19:15] == 5'd0)
            x2 = {{20{mem[0][31]}}, mem[0][31:20]};
        else
            x2 = -1;
        check("core_x2", 32'(x2), 32'd5);

        // reload in DONE
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("reload_done", {core_rst, done, in_ready, dbg_state}, {1'b1, 1'b0, 1'b1, 2'd0});
        check("reload_wc", 32'(word_count), 32'd0);

        // same image with in_valid toggling
        push_image();
        send_image(1);
        idle(1);
        check("gap_done", {done, core_rst}, {1'b1, 1'b0});
        check("gap_wc", 32'(word_count), 32'd3);

        // partial word: in_last on the 6th byte
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        exp_q.push_back({6'd0, 32'h44332211});
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h11 * (i + 1)), i == 5, 1'b0);
        check("partial_err", {err, core_rst, in_ready, done}, {1'b1, 1'b1, 1'b0, 1'b0});
        idle(2);
        check("partial_wc", 32'(word_count), 32'd1);
        check("partial_hold", {err, in_ready}, {1'b1, 1'b0});

        // reload coinciding with a valid byte in LOAD drops the byte
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        cycle(1'b1, 8'hBB, 1'b0, 1'b0);
        check("pre_drop_idx", 32'(dbg_byte_idx), 32'd2);
        cycle(1'b1, 8'hCC, 1'b0, 1'b1);
        check("drop", {imem_we, dbg_byte_idx, dbg_state}, {1'b0, 2'd0, 2'd0});
        exp_q.push_back({6'd0, 32'h04030201});
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(i + 1), 1'b0, 1'b0);
        idle(2);
        check("drop_wc", 32'(word_count), 32'd1);

        // async reset after byte 2 of word 1
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        exp_q.push_back({6'd0, 32'h00500113});
        for (int i = 0; i < 6; i++) cycle(1'b1, image[i], 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("arst_outputs", {in_ready, imem_we, core_rst, done, err, dbg_state, dbg_byte_idx},
              {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0});
        check("arst_fields", {26'(word_count), imem_addr}, 32'd0);
        check("arst_wdata", imem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        push_image();
        send_image(0);
        idle(1);
        check("rerun_done", {done, core_rst, 5'(word_count)}, {1'b1, 1'b0, 5'd3});

        // overflow on the DEPTH=4 instance, extra byte straight after the 4th commit
        ovf_sel = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        s_wr_cnt = 0;
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        check("ovf_before", {s_err, s_imem_we, s_in_ready}, {1'b0, 1'b1, 1'b1});
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        check("ovf_err", {s_err, s_in_ready, s_core_rst}, {1'b1, 1'b0, 1'b1});
        idle(3);
        check("ovf_wc", 32'(s_wc), 32'd4);
        check("ovf_writes", 32'(s_wr_cnt), 32'd4);
        ovf_sel = 1'b0;

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // absolute bound on the run
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
